// File: rtl/sensor_read_sched.sv
// Sensor read scheduler: coalesces client and periodic read requests, enforces a
// minimum gap between reads, times out / retries failed reads (retries built only with SENSOR_RETRY_EN).
module sensor_read_sched #(
  parameter int unsigned MIN_GAP_CYC = 100_000_000,
  parameter int unsigned PERIOD_CYC  = 250_000_000,
  parameter int unsigned TIMEOUT_CYC = 2_500_000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [1:0]  req,
  output logic [1:0]  ack,
  output logic        res_ok,
  output logic        rd_start,
  input  logic        rd_busy,
  input  logic        rd_done,
  input  logic        rd_ok,
  input  logic [31:0] rd_data,
  output logic [31:0] data,
  output logic        data_valid,
  output logic        stale,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam int CW = 28;
  localparam logic [CW-1:0] GAP_MAX  = CW'(MIN_GAP_CYC);
  localparam logic [CW-1:0] PER_LAST = CW'(PERIOD_CYC - 1);
  localparam logic [CW-1:0] TMO_LIM  = CW'(TIMEOUT_CYC);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GAP   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] period_cnt;
  logic [CW-1:0] gap_cnt;
  logic [CW-1:0] tmo_cnt;
  logic [1:0]    pending;
  logic          per_pend;
  logic [2:0]    serve;       // {periodic, client1, client0}
  logic          period_wrap;
  logic          any_pend;
  logic          gap_ok;
  logic          fresh;
  logic          read_good;
  logic          attempt_fail;
  logic          retry_ok;

  assign period_wrap  = (period_cnt >= PER_LAST);
  assign any_pend     = (|pending) | per_pend;
  assign gap_ok       = (gap_cnt >= GAP_MAX);
  // An empty serve mask in START means a new read; non-empty means a retry of the same clients.
  assign fresh        = (serve == 3'b000);
  assign read_good    = (state == S_WAIT) && rd_done && rd_ok;
  assign attempt_fail = (state == S_WAIT) && !read_good && (rd_done || (tmo_cnt >= TMO_LIM));
  assign busy         = (state != S_IDLE);

`ifdef SENSOR_RETRY_EN
  logic [CW-1:0] retry_cnt;

  assign retry_ok = (retry_cnt < CW'(MAX_RETRY));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      retry_cnt <= '0;
    end else if (state == S_START && fresh) begin
      retry_cnt <= '0;
    end else if (attempt_fail && retry_ok) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      period_cnt <= '0;
    end else if (period_wrap) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // Requests landing in the START cycle survive the clear and wait for the next read.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending  <= 2'b00;
      per_pend <= 1'b0;
    end else if (state == S_START && fresh) begin
      pending  <= req;
      per_pend <= period_wrap;
    end else begin
      pending  <= pending | req;
      per_pend <= per_pend | period_wrap;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_GAP;
      serve      <= 3'b000;
      gap_cnt    <= '0;
      tmo_cnt    <= '0;
      rd_start   <= 1'b0;
      ack        <= 2'b00;
      res_ok     <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      stale      <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      rd_start   <= 1'b0;
      ack        <= 2'b00;
      res_ok     <= 1'b0;
      data_valid <= 1'b0;
      if (!gap_ok) gap_cnt <= gap_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (any_pend && gap_ok && !rd_busy) begin
            state    <= S_START;
            rd_start <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_ok && !rd_busy) begin
            if (!fresh || any_pend) begin
              state    <= S_START;
              rd_start <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_START: begin
          if (fresh) serve <= {per_pend, pending};
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (read_good) begin
            data       <= rd_data;
            data_valid <= 1'b1;
            stale      <= 1'b0;
            ack        <= serve[1:0];
            res_ok     <= 1'b1;
            state      <= S_DONE;
          end else if (attempt_fail) begin
            if (retry_ok) begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end else begin
              stale  <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
              ack    <= serve[1:0];
              res_ok <= 1'b0;
              state  <= S_DONE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DONE: begin
          gap_cnt <= '0;
          serve   <= 3'b000;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_read_sched.sv
// Self-checking bench for sensor_read_sched: reader-core model, ack scoreboard,
// one task per scenario. Retry expectations follow SENSOR_RETRY_EN.
`timescale 1ns/1ps
module tb_sensor_read_sched;

  localparam int MIN_GAP   = 100;
  localparam int PERIOD    = 1000;
  localparam int TIMEOUT   = 50;
  localparam int MAX_RETRY = 2;
`ifdef SENSOR_RETRY_EN
  localparam int ATTEMPTS = MAX_RETRY + 1;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  ack;
  logic        res_ok;
  logic        rd_start;
  logic        rd_busy = 1'b0;
  logic        rd_done;
  logic        rd_ok;
  logic [31:0] rd_data;
  logic [31:0] data;
  logic        data_valid;
  logic        stale;
  logic [7:0]  err_cnt;
  logic        busy;

  sensor_read_sched #(
    .MIN_GAP_CYC(MIN_GAP), .PERIOD_CYC(PERIOD), .TIMEOUT_CYC(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req(req), .ack(ack), .res_ok(res_ok),
    .rd_start(rd_start), .rd_busy(rd_busy), .rd_done(rd_done), .rd_ok(rd_ok),
    .rd_data(rd_data), .data(data), .data_valid(data_valid), .stale(stale),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [1:0]  ack;
    logic        ok;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc = 0;
  int start_cnt = 0, dv_cnt = 0, ack_cnt = 0;
  int last_start_cyc = 0, last_ack_cyc = 0, prev_ack_cyc = 0;

  // Reader-model controls (written by the test sequence only).
  int          fail_until = 0;
  bit          rd_silent = 1'b0;
  int          rd_lat = 3;
  logic [31:0] data_base = '0;
  int          stray_req = 0;
  // Reader-model state (written by the reader only).
  int          resp_idx = 0;
  int          stray_seen = 0;

  always @(posedge sys_clk) cyc++;

  // Monitor: start spacing, data_valid count, ack scoreboard.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      last_start_cyc = cyc;
    end else begin
      if (rd_start === 1'b1) begin
        n_checks++;
        if (cyc - last_start_cyc < MIN_GAP) begin
          n_fails++;
          $display("FAIL start_spacing: %0d cycles since previous start or reset, required >= %0d",
                   cyc - last_start_cyc, MIN_GAP);
        end
        start_cnt++;
        last_start_cyc = cyc;
      end
      if (data_valid === 1'b1) dv_cnt++;
      if (ack !== 2'b00) begin
        prev_ack_cyc = last_ack_cyc;
        last_ack_cyc = cyc;
        ack_cnt++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fails++;
          $display("FAIL unexpected_ack: ack=%b res_ok=%b, required no ack", ack, res_ok);
        end else begin
          mon_e = sb.pop_front();
          if (ack !== mon_e.ack || res_ok !== mon_e.ok || (mon_e.chk_data && data !== mon_e.data)) begin
            n_fails++;
            $display("FAIL ack_result: ack=%b res_ok=%b data=%h, required ack=%b res_ok=%b data=%h",
                     ack, res_ok, data, mon_e.ack, mon_e.ok, mon_e.data);
          end
        end
      end
    end
  end

  // Reader core model: answers each rd_start after rd_lat cycles unless silent.
  initial begin : reader
    rd_done = 1'b0;
    rd_ok   = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge sys_clk);
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        rd_done = 1'b1;
        rd_ok   = 1'b1;
        rd_data = 32'hDEAD_BEEF;
        @(negedge sys_clk);
        rd_done = 1'b0;
        rd_ok   = 1'b0;
      end else if (rd_start === 1'b1 && sys_rst_n && !rd_silent) begin
        repeat (rd_lat - 1) @(negedge sys_clk);
        rd_data = data_base + 32'(resp_idx);
        rd_ok   = (resp_idx >= fail_until);
        resp_idx++;
        rd_done = 1'b1;
        @(negedge sys_clk);
        rd_done = 1'b0;
        rd_ok   = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic pulse_req(input logic [1:0] r);
    req = r;
    @(negedge sys_clk);
    req = 2'b00;
  endtask

  task automatic do_reset();
    sys_rst_n  = 1'b0;
    req        = 2'b00;
    rd_busy    = 1'b0;
    rd_silent  = 1'b0;
    rd_lat     = 3;
    fail_until = 0;
    sb.delete();
    tick(3);
    sys_rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL %s: %0d acks outstanding after %0d cycles, required 0", name, sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic wait_start(input string name, input int s0, input int budget);
    int n = 0;
    while (start_cnt == s0 && n < budget) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (start_cnt == s0) begin
      n_fails++;
      $display("FAIL %s: no rd_start within %0d cycles, required one", name, budget);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    tick(2);
    n_checks += 4;
    if ({ack, res_ok, rd_start, data_valid, stale} !== 6'b0) begin
      n_fails++;
      $display("FAIL reset_pulses: {ack,res_ok,rd_start,data_valid,stale}=%b, required 0",
               {ack, res_ok, rd_start, data_valid, stale});
    end
    if (data !== 32'h0) begin
      n_fails++;
      $display("FAIL reset_data: data=%h, required 00000000", data);
    end
    if (err_cnt !== 8'd0) begin
      n_fails++;
      $display("FAIL reset_err_cnt: err_cnt=%0d, required 0", err_cnt);
    end
    if (busy !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_busy: busy=%b, required 1 (GAP state)", busy);
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    int s0, d0;
    do_reset();
    s0 = start_cnt;
    d0 = dv_cnt;
    tick(10);
    data_base = 32'h3700_1A05 - 32'(resp_idx);
    sb.push_back('{ack: 2'b01, ok: 1'b1, chk_data: 1'b1, data: 32'h3700_1A05});
    pulse_req(2'b01);
    wait_drain("single_read", 400);
    n_checks += 3;
    if (start_cnt - s0 != 1) begin
      n_fails++;
      $display("FAIL single_starts: %0d rd_start pulses, required 1", start_cnt - s0);
    end
    if (dv_cnt - d0 != 1 || data !== 32'h3700_1A05) begin
      n_fails++;
      $display("FAIL single_data: %0d data_valid pulses data=%h, required 1 and 37001a05", dv_cnt - d0, data);
    end
    if (stale !== 1'b0) begin
      n_fails++;
      $display("FAIL single_stale: stale=%b, required 0", stale);
    end
  endtask

  task automatic test_coalesce();
    int s0;
    do_reset();
    s0 = start_cnt;
    tick(5);
    data_base = 32'h1234_0000 - 32'(resp_idx);
    sb.push_back('{ack: 2'b11, ok: 1'b1, chk_data: 1'b1, data: 32'h1234_0000});
    pulse_req(2'b01);
    tick(15);
    pulse_req(2'b10);
    wait_drain("coalesce", 400);
    n_checks++;
    if (start_cnt - s0 != 1) begin
      n_fails++;
      $display("FAIL coalesce_starts: %0d rd_start pulses, required 1", start_cnt - s0);
    end
  endtask

  task automatic test_retry();
    int s0;
    do_reset();
    s0 = start_cnt;
    fail_until = resp_idx + ATTEMPTS;
    sb.push_back('{ack: 2'b01, ok: 1'b0, chk_data: 1'b0, data: 32'h0});
    pulse_req(2'b01);
    wait_drain("retry_fail", 1000);
    n_checks += 2;
    if (start_cnt - s0 != ATTEMPTS) begin
      n_fails++;
      $display("FAIL retry_starts: %0d rd_start pulses, required %0d", start_cnt - s0, ATTEMPTS);
    end
    if (stale !== 1'b1 || err_cnt !== 8'd1) begin
      n_fails++;
      $display("FAIL retry_final: stale=%b err_cnt=%0d, required 1 and 1", stale, err_cnt);
    end
    data_base = 32'h5555_AAAA - 32'(resp_idx);
    sb.push_back('{ack: 2'b01, ok: 1'b1, chk_data: 1'b1, data: 32'h5555_AAAA});
    pulse_req(2'b01);
    wait_drain("retry_recover", 400);
    n_checks++;
    if (stale !== 1'b0 || err_cnt !== 8'd1) begin
      n_fails++;
      $display("FAIL retry_recover: stale=%b err_cnt=%0d, required 0 and 1", stale, err_cnt);
    end
  endtask

  task automatic test_timeout();
    int s0;
    do_reset();
    rd_silent = 1'b1;
    s0 = start_cnt;
    sb.push_back('{ack: 2'b01, ok: 1'b0, chk_data: 1'b0, data: 32'h0});
    pulse_req(2'b01);
    wait_drain("timeout", 800);
    n_checks += 3;
    if (stale !== 1'b1 || err_cnt !== 8'd1) begin
      n_fails++;
      $display("FAIL timeout_final: stale=%b err_cnt=%0d, required 1 and 1", stale, err_cnt);
    end
    if (last_ack_cyc - last_start_cyc < TIMEOUT || last_ack_cyc - last_start_cyc > TIMEOUT + 4) begin
      n_fails++;
      $display("FAIL timeout_latency: %0d cycles start to ack, required %0d..%0d",
               last_ack_cyc - last_start_cyc, TIMEOUT, TIMEOUT + 4);
    end
    tick(300);
    if (start_cnt - s0 != ATTEMPTS) begin
      n_fails++;
      $display("FAIL timeout_starts: %0d rd_start pulses, required %0d", start_cnt - s0, ATTEMPTS);
    end
    rd_silent = 1'b0;
  endtask

  task automatic test_rd_busy();
    int s0;
    do_reset();
    s0 = start_cnt;
    rd_busy = 1'b1;
    data_base = 32'h0A0B_0C0D - 32'(resp_idx);
    sb.push_back('{ack: 2'b10, ok: 1'b1, chk_data: 1'b1, data: 32'h0A0B_0C0D});
    pulse_req(2'b10);
    tick(300);
    n_checks += 2;
    if (start_cnt != s0) begin
      n_fails++;
      $display("FAIL busy_hold: %0d rd_start pulses while rd_busy, required 0", start_cnt - s0);
    end
    rd_busy = 1'b0;
    wait_drain("busy_release", 200);
    if (start_cnt - s0 != 1) begin
      n_fails++;
      $display("FAIL busy_release_starts: %0d rd_start pulses, required 1", start_cnt - s0);
    end
  endtask

  task automatic test_back_to_back();
    int s0, d0;
    do_reset();
    rd_lat = 20;
    s0 = start_cnt;
    data_base = 32'h0000_1000 - 32'(resp_idx);
    sb.push_back('{ack: 2'b01, ok: 1'b1, chk_data: 1'b1, data: 32'h0000_1000});
    sb.push_back('{ack: 2'b10, ok: 1'b1, chk_data: 1'b1, data: 32'h0000_1001});
    pulse_req(2'b01);
    wait_start("b2b_first_start", s0, 300);
    tick(5);
    pulse_req(2'b10);
    wait_drain("back_to_back", 600);
    rd_lat = 3;
    n_checks += 3;
    if (start_cnt - s0 != 2) begin
      n_fails++;
      $display("FAIL b2b_starts: %0d rd_start pulses, required 2", start_cnt - s0);
    end
    if (last_start_cyc - prev_ack_cyc < MIN_GAP) begin
      n_fails++;
      $display("FAIL b2b_gap: %0d cycles first ack to second start, required >= %0d",
               last_start_cyc - prev_ack_cyc, MIN_GAP);
    end
    tick(2);
    if (busy !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_idle: busy=%b, required 0", busy);
    end
    d0 = dv_cnt;
    stray_req++;
    tick(6);
    n_checks++;
    if (data !== 32'h0000_1001 || dv_cnt != d0 || stale !== 1'b0) begin
      n_fails++;
      $display("FAIL stray_done: data=%h dv_pulses=%0d stale=%b, required 00001001 0 0",
               data, dv_cnt - d0, stale);
    end
  endtask

  task automatic test_reset_abort();
    int s0, a0;
    do_reset();
    rd_silent = 1'b1;
    s0 = start_cnt;
    a0 = ack_cnt;
    pulse_req(2'b01);
    wait_start("abort_start", s0, 300);
    tick(10);
    n_checks += 2;
    if (busy !== 1'b1) begin
      n_fails++;
      $display("FAIL abort_busy: busy=%b mid-read, required 1", busy);
    end
    do_reset();
    tick(200);
    if (ack_cnt != a0 || start_cnt - s0 != 1 || err_cnt !== 8'd0) begin
      n_fails++;
      $display("FAIL abort_result: acks=%0d starts=%0d err_cnt=%0d, required 0 1 0",
               ack_cnt - a0, start_cnt - s0, err_cnt);
    end
  endtask

  task automatic test_periodic();
    int s0, d0, a0;
    do_reset();
    s0 = start_cnt;
    d0 = dv_cnt;
    a0 = ack_cnt;
    data_base = 32'h0BAD_F00D - 32'(resp_idx);
    tick(2300);
    n_checks += 2;
    if (start_cnt - s0 != 2 || dv_cnt - d0 != 2 || ack_cnt != a0) begin
      n_fails++;
      $display("FAIL periodic_reads: starts=%0d dv=%0d acks=%0d, required 2 2 0",
               start_cnt - s0, dv_cnt - d0, ack_cnt - a0);
    end
    if (data !== 32'h0BAD_F00E) begin
      n_fails++;
      $display("FAIL periodic_data: data=%h, required 0badf00e", data);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    fail_until = resp_idx + 100000;
    for (int i = 0; i < 260; i++) begin
      sb.push_back('{ack: 2'b01, ok: 1'b0, chk_data: 1'b0, data: 32'h0});
      pulse_req(2'b01);
      wait_drain("saturate_step", 600);
      if (i == 254) begin
        n_checks++;
        if (err_cnt !== 8'd255) begin
          n_fails++;
          $display("FAIL saturate_reach: err_cnt=%0d after 255 failures, required 255", err_cnt);
        end
      end
    end
    n_checks++;
    if (err_cnt !== 8'd255 || stale !== 1'b1) begin
      n_fails++;
      $display("FAIL saturate_hold: err_cnt=%0d stale=%b, required 255 and 1", err_cnt, stale);
    end
    fail_until = 0;
  endtask

  initial begin
    #5;
    test_reset();
    test_single_read();
    test_coalesce();
    test_retry();
    test_timeout();
    test_rd_busy();
    test_back_to_back();
    test_reset_abort();
    test_periodic();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin : watchdog
    #(64'd3_000_000);
    $display("FAIL watchdog: simulation exceeded 150000 cycles, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
